event_horizon_pipe: RTL and testbench
=====================================

# event_horizon_pipe

Parametrised multi-channel event delay and classification pipeline. Each of WIDTH input event bits is delayed by DEPTH enabled clock cycles to b. One cycle later, each delayed bit is classified into a CODE_W-bit status code on c. Per-channel rising edges on the delayed stream are counted, with a saturating limit. The block supports stall, flush and fill-valid tracking, and sits between event sources and downstream status/decode logic.

## Interface
- WIDTH, 2: number of independent event channels (≥1)
- DEPTH, 1: delay stages from a to b (≥1; 0 is illegal)
- CODE_W, 3: width of each per-channel status code
- CODE_ONE, 3'b010: code emitted when the classified b bit was 1
- CODE_ZERO, 3'b011: code emitted when the classified b bit was 0
- CNT_W, 8: width of each per-channel rising-edge counter
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clears all state
- en  in  1  advance enable; 0 = stall, all state holds
- flush  in  1  clears delay stages and valids; counters kept
- cnt_clr  in  1  clears all edge counters
- a  in  WIDTH  input event bits, bit i = channel i
- b  out  WIDTH  a delayed DEPTH enabled cycles (stage DEPTH-1 register)
- b_valid  out  1  b holds data sampled from a since last reset/flush
- c  out  WIDTH*CODE_W  status codes; channel i at [i*CODE_W +: CODE_W]
- c_valid  out  1  c derived from a valid b
- rise  out  WIDTH  one-cycle pulse per channel on a b rising edge
- cnt  out  WIDTH*CNT_W  saturating rising-edge counts; channel i at [i*CNT_W +: CNT_W]

## Operation
- Delay line: DEPTH registered stages, each WIDTH wide. On an enabled cycle, stage0 <= a and stage k <= stage k-1. b = last stage.
- Fill tracking: a DEPTH-bit valid shift register, fed with 1 on each enabled cycle. b_valid is its last bit. c_valid <= b_valid on enabled cycles.
- Classification: on an enabled cycle, c[i] <= b[i] ? CODE_ONE : CODE_ZERO, using the pre-edge value of b. Classification occurs regardless of b_valid.
- Edge detect: a per-channel register `last` holds b as sampled on the previous enabled cycle.
  - On an enabled cycle with b_valid=1: rise[i] <= b[i] & ~last[i], and last <= b.
  - On any other cycle, rise <= 0.
- Counters: cnt[i] increments on a cycle where rise[i] is being set to 1. The count saturates at 2^CNT_W-1 and never wraps.
- Stall (en=0): delay stages, valids, c, last and cnt hold; rise <= 0.
- Flush (not reset): delay stages <= 0, valid shift register <= 0, b_valid = c_valid = 0, last <= 0, rise <= 0, c <= CODE_ZERO on all channels. cnt is unaffected.
- Priority: reset > flush > en.
  - flush with en=1: flush wins and a is not captured.
  - cnt_clr together with an increment: clear wins, and cnt = 0 next cycle.
  - cnt_clr acts independently of en and flush.
- Reset values: b = 0, b_valid = 0, c = CODE_ZERO on every channel, c_valid = 0, rise = 0, cnt = 0, last = 0, all stages = 0.
- Reset mid-operation: all in-flight data is discarded, and the fill restarts from empty.

## Timing
- Latency with en held at 1:
  - b(t+DEPTH) = a(t)
  - c(t+DEPTH+1) = code(a(t))
  - rise/cnt update at t+DEPTH+1
- After reset or flush, with continuous en:
  - b_valid rises on the DEPTH-th enabled edge.
  - c_valid rises one enabled edge later.
- Stall cycles add latency one-for-one. No sample is dropped or duplicated across a stall.
- With DEPTH=1, WIDTH=1 and en=1, the behaviour is the classic two-register form: b <= a; c <= b ? CODE_ONE : CODE_ZERO.
- rise is never high for two consecutive cycles on a channel unless b toggles 0→1 on consecutive enabled samples, which is impossible. A back-to-back rise is therefore a bug.

## Test plan
Bench parameters: WIDTH=2, DEPTH=3, CNT_W=2.

- **Reset:** reset=1 for 2 cycles with a=2'b11 → b=0, c={3'b011,3'b011}, b_valid=c_valid=0, cnt=0, rise=0.
- **Latency/fill:** en=1, a=2'b01 at cycle 0 and 2'b00 afterwards.
  - b=2'b01 at cycle 3, with b_valid first high at cycle 3.
  - c[2:0]=3'b010 and c[5:3]=3'b011 at cycle 4, with c_valid high at cycle 4.
  - rise=2'b01 at cycle 4 only; cnt ch0 = 1.
- **Stall:** same stimulus as the latency test, with en=0 for cycles 1-2 → b=2'b01 arrives at cycle 5. Outputs hold during the stall, and rise is 0 during the stall.
- **Saturation/clear:** toggle a[1] 0/1 repeatedly for 5 edges.
  - cnt ch1 goes 1, 2, 3, 3, 3.
  - cnt_clr is asserted on a cycle that also carries an increment → cnt ch1 = 0.
- **Flush:** assert flush with en=1 mid-stream while a[0]=1 is in flight.
  - Next cycle: b=0, b_valid=0, c=CODE_ZERO, cnt unchanged.
  - The pre-flush sample never appears on b.
- **Priority:** reset and flush asserted together during a count → all outputs take their reset values, including cnt=0.

Source files
------------

// File: rtl/event_horizon_pipe.sv
`default_nettype none
// event_horizon_pipe: per-channel event delay line with status classification,
// rising-edge detection and saturating edge counters. Rev 1.0
module event_horizon_pipe #(
  parameter int                WIDTH     = 2,
  parameter int                DEPTH     = 1,
  parameter int                CODE_W    = 3,
  parameter logic [CODE_W-1:0] CODE_ONE  = 3'b010,
  parameter logic [CODE_W-1:0] CODE_ZERO = 3'b011,
  parameter int                CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    cnt_clr,
  input  logic [WIDTH-1:0]        a,
  output logic [WIDTH-1:0]        b,
  output logic                    b_valid,
  output logic [WIDTH*CODE_W-1:0] c,
  output logic                    c_valid,
  output logic [WIDTH-1:0]        rise,
  output logic [WIDTH*CNT_W-1:0]  cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]        stage_q [DEPTH];
  logic [WIDTH-1:0]        stage_d [DEPTH];
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [WIDTH*CODE_W-1:0] c_q, c_d;
  logic                    c_valid_q, c_valid_d;
  logic [WIDTH-1:0]        last_q, last_d;
  logic [WIDTH-1:0]        rise_q, rise_d;
  logic [WIDTH*CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    stage_d   = stage_q;
    vld_d     = vld_q;
    c_d       = c_q;
    c_valid_d = c_valid_q;
    last_d    = last_q;
    rise_d    = '0;
    cnt_d     = cnt_q;

    if (flush) begin
      for (int k = 0; k < DEPTH; k++) stage_d[k] = '0;
      vld_d     = '0;
      c_valid_d = 1'b0;
      last_d    = '0;
      for (int i = 0; i < WIDTH; i++) c_d[i*CODE_W +: CODE_W] = CODE_ZERO;
    end else if (en) begin
      stage_d[0] = a;
      for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
      vld_d[0] = 1'b1;
      for (int k = 1; k < DEPTH; k++) vld_d[k] = vld_q[k-1];
      c_valid_d = vld_q[DEPTH-1];
      // Classification uses the pre-edge b, valid or not.
      for (int i = 0; i < WIDTH; i++)
        c_d[i*CODE_W +: CODE_W] = stage_q[DEPTH-1][i] ? CODE_ONE : CODE_ZERO;
      if (vld_q[DEPTH-1]) begin
        rise_d = stage_q[DEPTH-1] & ~last_q;
        last_d = stage_q[DEPTH-1];
      end
    end

    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_clr)
        cnt_d[i*CNT_W +: CNT_W] = '0;
      else if (rise_d[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX))
        cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q   <= '{default: '0};
      vld_q     <= '0;
      c_q       <= {WIDTH{CODE_ZERO}};
      c_valid_q <= 1'b0;
      last_q    <= '0;
      rise_q    <= '0;
      cnt_q     <= '0;
    end else begin
      stage_q   <= stage_d;
      vld_q     <= vld_d;
      c_q       <= c_d;
      c_valid_q <= c_valid_d;
      last_q    <= last_d;
      rise_q    <= rise_d;
      cnt_q     <= cnt_d;
    end
  end

  assign b       = stage_q[DEPTH-1];
  assign b_valid = vld_q[DEPTH-1];
  assign c       = c_q;
  assign c_valid = c_valid_q;
  assign rise    = rise_q;
  assign cnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_event_horizon_pipe.sv
`default_nettype none
// tb_event_horizon_pipe: directed plus randomized checks against a
// sample-history reference model. Rev 1.0
module tb_event_horizon_pipe;

  localparam int         WIDTH  = 2;
  localparam int         DEPTH  = 3;
  localparam int         CODE_W = 3;
  localparam int         CNT_W  = 2;
  localparam logic [2:0] C_ONE  = 3'b010;
  localparam logic [2:0] C_ZERO = 3'b011;
  localparam int         CMAX   = 3;

  logic                    clk = 1'b0;
  logic                    reset, en, flush, cnt_clr;
  logic [WIDTH-1:0]        a, b, rise;
  logic                    b_valid, c_valid;
  logic [WIDTH*CODE_W-1:0] c;
  logic [WIDTH*CNT_W-1:0]  cnt;

  always #5 clk = ~clk;

  event_horizon_pipe #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CODE_W(CODE_W),
    .CODE_ONE(C_ONE), .CODE_ZERO(C_ZERO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
    .a(a), .b(b), .b_valid(b_valid), .c(c), .c_valid(c_valid),
    .rise(rise), .cnt(cnt)
  );

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [1:0] hist [$];   // samples accepted since last reset/flush
  int         cnt_m [2];
  logic [1:0] rise_m;
  logic [1:0] rise_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] h(input int idx);
    return (idx >= 0 && idx < hist.size()) ? hist[idx] : 2'b00;
  endfunction

  function automatic logic [5:0] code(input logic [1:0] v);
    return {v[1] ? C_ONE : C_ZERO, v[0] ? C_ONE : C_ZERO};
  endfunction

  task automatic check_all();
    int n;
    n = hist.size();
    chk("b",        b,       h(n - DEPTH));
    chk("b_valid",  b_valid, n >= DEPTH);
    chk("c",        c,       code(h(n - 1 - DEPTH)));
    chk("c_valid",  c_valid, n > DEPTH);
    chk("rise",     rise,    rise_m);
    chk("cnt",      cnt,     {2'(cnt_m[1]), 2'(cnt_m[0])});
    chk("rise_b2b", rise & rise_prev, 2'b00);
    rise_prev = rise;
  endtask

  task automatic step(input logic r, input logic f, input logic e,
                      input logic cc, input logic [1:0] av);
    reset = r; flush = f; en = e; cnt_clr = cc; a = av;
    @(posedge clk);
    rise_m = 2'b00;
    if (r) begin
      hist.delete();
      cnt_m[0] = 0;
      cnt_m[1] = 0;
    end else begin
      if (f) hist.delete();
      else if (e) begin
        hist.push_back(av);
        // b before this edge vs. the previous valid b sample
        rise_m = h(hist.size() - 1 - DEPTH) & ~h(hist.size() - 2 - DEPTH);
      end
      for (int i = 0; i < 2; i++) begin
        if (cc) cnt_m[i] = 0;
        else if (rise_m[i] && cnt_m[i] < CMAX) cnt_m[i]++;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rise_prev = 2'b00;
    reset = 1'b1; flush = 1'b0; en = 1'b0; cnt_clr = 1'b0; a = 2'b00;
    @(negedge clk);

    // Reset
    step(1, 0, 0, 0, 2'b11);
    step(1, 0, 0, 0, 2'b11);
    chk("rst_b",  b, 2'b00);
    chk("rst_c",  c, 6'b011011);
    chk("rst_cnt", cnt, 4'd0);

    // Latency / fill
    step(0, 0, 1, 0, 2'b01);
    step(0, 0, 1, 0, 2'b00);
    step(0, 0, 1, 0, 2'b00);
    chk("lat_b",  b, 2'b01);
    chk("lat_bv", b_valid, 1'b1);
    step(0, 0, 1, 0, 2'b00);
    chk("lat_c",    c, 6'b011010);
    chk("lat_rise", rise, 2'b01);
    chk("lat_cnt0", cnt[1:0], 2'd1);
    step(0, 0, 1, 0, 2'b00);

    // Stall
    step(1, 0, 0, 0, 2'b00);
    step(0, 0, 1, 0, 2'b01);
    step(0, 0, 0, 0, 2'b11);
    step(0, 0, 0, 0, 2'b11);
    step(0, 0, 1, 0, 2'b00);
    step(0, 0, 1, 0, 2'b00);
    chk("stall_b", b, 2'b01);
    step(0, 0, 1, 0, 2'b00);

    // Saturation / clear on channel 1
    for (int k = 0; k < 14; k++) step(0, 0, 1, 0, (k % 2 == 0) ? 2'b10 : 2'b00);
    chk("sat_cnt1", cnt[3:2], 2'd3);
    for (int k = 0; k < 2; k++) step(0, 0, 1, 1, (k % 2 == 0) ? 2'b10 : 2'b00);
    chk("clr_cnt1", cnt[3:2], 2'd0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 0, (k % 2 == 0) ? 2'b10 : 2'b00);

    // Flush with a[0]=1 in flight
    step(0, 0, 1, 0, 2'b01);
    step(0, 1, 1, 0, 2'b11);
    chk("fl_b",  b, 2'b00);
    chk("fl_bv", b_valid, 1'b0);
    chk("fl_c",  c, 6'b011011);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 2'b00);

    // Reset and flush together during counting
    for (int k = 0; k < 8; k++) step(0, 0, 1, 0, (k % 2 == 0) ? 2'b11 : 2'b00);
    step(1, 1, 1, 0, 2'b11);
    chk("prio_cnt", cnt, 4'd0);
    chk("prio_c",   c, 6'b011011);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 32) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 32) == 0,
           2'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
